// File: rtl/register_driver.sv
// Command-side initiator that turns valid/ready ops into one-hot register control pulses.
// Optional shadow model of the driven register is enabled with `define REG_DRIVER_MIRROR_EN.
module register_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             cl,
  output logic             ld,
  output logic             inc,
  output logic             dec,
  output logic             sr,
  output logic             ir,
  output logic             sl,
  output logic             il,
  output logic [WIDTH-1:0] ld_data,
  output logic             busy,
  output logic             done,
`ifdef REG_DRIVER_MIRROR_EN
  input  logic [WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0] mirror_q,
  output logic             mismatch,
`endif
  output logic             err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  logic [1:0]       state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] arg_r;
  logic [CNT_W-1:0] rem;
  logic [IDX_W-1:0] idx;

  logic [2:0]       fire_op;
  logic [WIDTH-1:0] fire_arg;
  logic             fire_bit;

  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(WIDTH - 1)) return {IDX_W{1'b0}};
    else return i + IDX_W'(1);
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Select the pulse (if any) to present after the coming edge; rem counts pulses still owed including the current one.
  always_comb begin
    fire_op  = OP_NOP;
    fire_arg = {WIDTH{1'b0}};
    fire_bit = 1'b0;
    if (state == IDLE && cmd_valid && cmd_op != OP_NOP && cmd_op != OP_RSV) begin
      fire_op  = cmd_op;
      fire_arg = cmd_arg;
      fire_bit = cmd_arg[0];
    end else if (state == EXEC && rem != CNT_W'(1)) begin
      fire_op  = op_r;
      fire_arg = arg_r;
      fire_bit = arg_r[idx];
    end else begin
      fire_op  = OP_NOP;
    end
  end

  // Registered one-hot control pulses and their qualified data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cl      <= 1'b0;
      ld      <= 1'b0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      sr      <= 1'b0;
      sl      <= 1'b0;
      ir      <= 1'b0;
      il      <= 1'b0;
      ld_data <= {WIDTH{1'b0}};
    end else begin
      cl      <= (fire_op == OP_CLR);
      ld      <= (fire_op == OP_LOAD);
      inc     <= (fire_op == OP_INC);
      dec     <= (fire_op == OP_DEC);
      sr      <= (fire_op == OP_SHR);
      sl      <= (fire_op == OP_SHL);
      ir      <= (fire_op == OP_SHR) && fire_bit;
      il      <= (fire_op == OP_SHL) && fire_bit;
      ld_data <= (fire_op == OP_LOAD) ? fire_arg : {WIDTH{1'b0}};
    end
  end

  // Command FSM: accept, count pulses down (no wrap), then a single done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_r  <= 3'd0;
      arg_r <= {WIDTH{1'b0}};
      rem   <= {CNT_W{1'b0}};
      idx   <= {IDX_W{1'b0}};
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (cmd_valid) begin
            op_r  <= cmd_op;
            arg_r <= cmd_arg;
            idx   <= idx_step({IDX_W{1'b0}});
            if (cmd_op == OP_CLR || cmd_op == OP_LOAD || cmd_cnt == {CNT_W{1'b0}})
              rem <= CNT_W'(1);
            else
              rem <= cmd_cnt;
            if (cmd_op == OP_NOP || cmd_op == OP_RSV) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= (cmd_op == OP_RSV);
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (rem == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b0;
          end else begin
            rem <= rem - CNT_W'(1);
            idx <= idx_step(idx);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

`ifdef REG_DRIVER_MIRROR_EN
  // Shadow copy of the driven register, following the same pulse priority it uses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   mirror_q <= {WIDTH{1'b0}};
    else if (cl)  mirror_q <= {WIDTH{1'b0}};
    else if (ld)  mirror_q <= ld_data;
    else if (inc) mirror_q <= mirror_q + WIDTH'(1);
    else if (dec) mirror_q <= mirror_q - WIDTH'(1);
    else if (sr)  mirror_q <= {ir, mirror_q[WIDTH-1:1]};
    else if (sl)  mirror_q <= {mirror_q[WIDTH-2:0], il};
    else          mirror_q <= mirror_q;
  end

  assign mismatch = (state == IDLE) && (mirror_q != reg_q);
`endif

endmodule
